// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle for mem_bus_arbiter: CPU fetch/data ports, flush, stall
// outputs and the shared-bus command/response. The arbiter uses the master
// modport (it masters the shared bus); the surrounding system uses slave.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              flush;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              bus_req;
    logic              bus_we;
    logic [3:0]        bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    logic              stallreq_if;
    logic              stallreq_mem;

    modport master (
        input  flush,
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack,
        output stallreq_if, stallreq_mem
    );

    modport slave (
        output flush,
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        output bus_rdata, bus_ack,
        input  stallreq_if, stallreq_mem
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single shared memory bus: data accesses have
// strict priority over instruction fetch, one transaction outstanding at a
// time, and a pipeline flush can abandon (drain) an in-flight fetch.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.master  arb
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IF_BUSY  = 2'd1;
    localparam logic [1:0] MEM_BUSY = 2'd2;
    localparam logic [1:0] IF_DRAIN = 2'd3;

    logic [1:0]        state;
    logic              bus_req_r;
    logic              bus_we_r;
    logic [3:0]        bus_sel_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] mem_rdata_r;
    logic              if_ready_r;
    logic              mem_ready_r;

    // Arbitration FSM with the registered bus command and response capture.
    // A requester still holds its level request in the cycle its ready pulse
    // is out, so a request is only accepted while its own ready is low;
    // otherwise a completed access would be issued a second time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_sel_r   <= '0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
            if_rdata_r  <= '0;
            mem_rdata_r <= '0;
            if_ready_r  <= 1'b0;
            mem_ready_r <= 1'b0;
        end else begin
            if_ready_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb.mem_req && !mem_ready_r) begin
                        state       <= MEM_BUSY;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= arb.mem_we;
                        bus_sel_r   <= arb.mem_sel;
                        bus_addr_r  <= arb.mem_addr;
                        bus_wdata_r <= arb.mem_wdata;
                    end else if (arb.if_req && !if_ready_r && !arb.flush) begin
                        state       <= IF_BUSY;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= 1'b0;
                        bus_sel_r   <= '1;
                        bus_addr_r  <= arb.if_addr;
                        bus_wdata_r <= '0;
                    end
                end
                MEM_BUSY: begin
                    if (arb.bus_ack) begin
                        state       <= IDLE;
                        bus_req_r   <= 1'b0;
                        mem_ready_r <= 1'b1;
                        if (!bus_we_r) begin
                            mem_rdata_r <= arb.bus_rdata;
                        end
                    end
                end
                IF_BUSY: begin
                    if (arb.bus_ack) begin
                        state     <= IDLE;
                        bus_req_r <= 1'b0;
                        if (!arb.flush) begin
                            if_rdata_r <= arb.bus_rdata;
                            if_ready_r <= 1'b1;
                        end
                    end else if (arb.flush) begin
                        state <= IF_DRAIN;
                    end
                end
                IF_DRAIN: begin
                    if (arb.bus_ack) begin
                        state     <= IDLE;
                        bus_req_r <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Drive registered results and combinational stall requests.
    always_comb begin
        arb.bus_req      = bus_req_r;
        arb.bus_we       = bus_we_r;
        arb.bus_sel      = bus_sel_r;
        arb.bus_addr     = bus_addr_r;
        arb.bus_wdata    = bus_wdata_r;
        arb.if_rdata     = if_rdata_r;
        arb.if_ready     = if_ready_r;
        arb.mem_rdata    = mem_rdata_r;
        arb.mem_ready    = mem_ready_r;
        arb.stallreq_if  = arb.if_req && !if_ready_r;
        arb.stallreq_mem = arb.mem_req && !mem_ready_r;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a bus-slave model pops expected
// commands as the DUT issues them and answers with the queued read data;
// ready pulses are matched against expected-result queues.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bif.master)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        cmd_t c;
        c.we = we; c.sel = sel; c.addr = addr; c.wdata = wdata; c.rdata = rdata; c.delay = delay;
        cmd_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus-slave model and output monitor, evaluated on the falling edge.
    cmd_t cur;
    logic prev_req  = 1'b0;
    bit   active    = 1'b0;
    int   k         = 0;
    int   cyc       = 0;
    int   stray_cyc = -1;

    always @(negedge clk) begin
        bif.bus_ack = 1'b0;
        if (cyc == stray_cyc) begin
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = 32'hBAD0_BAD0;
        end
        if (bif.bus_req) begin
            if (!prev_req) begin
                if (cmd_q.size() == 0) begin
                    check("bus_req_unexp", bif.bus_req, 1'b0);
                    active = 1'b0;
                end else begin
                    cur    = cmd_q.pop_front();
                    active = 1'b1;
                    k      = 0;
                end
            end
            if (active) begin
                check("bus_we",    bif.bus_we,    cur.we);
                check("bus_sel",   bif.bus_sel,   cur.sel);
                check("bus_addr",  bif.bus_addr,  cur.addr);
                check("bus_wdata", bif.bus_wdata, cur.wdata);
                k++;
                if (k == cur.delay + 1) begin
                    bif.bus_ack   = 1'b1;
                    bif.bus_rdata = cur.rdata;
                end
            end
        end else begin
            active = 1'b0;
        end
        prev_req = bif.bus_req;

        if (bif.if_ready) begin
            if (if_q.size() == 0) check("if_ready_unexp", bif.if_ready, 1'b0);
            else                  check("if_rdata", bif.if_rdata, if_q.pop_front());
        end
        if (bif.mem_ready) begin
            if (mem_q.size() == 0) check("mem_ready_unexp", bif.mem_ready, 1'b0);
            else                   check("mem_rdata", bif.mem_rdata, mem_q.pop_front());
        end
        cyc++;
    end

    // Wait for a ready pulse with a cycle budget, checking the stall output.
    task automatic wait_ready(input bit is_mem, input int max, output int cycles);
        bit seen = 1'b0;
        logic rdy, stall;
        cycles = 0;
        for (int i = 1; i <= max && !seen; i++) begin
            step();
            cycles = i;
            rdy   = is_mem ? bif.mem_ready    : bif.if_ready;
            stall = is_mem ? bif.stallreq_mem : bif.stallreq_if;
            if (rdy) begin
                seen = 1'b1;
                check(is_mem ? "stallreq_mem_done" : "stallreq_if_done", stall, 1'b0);
            end else begin
                check(is_mem ? "stallreq_mem_wait" : "stallreq_if_wait", stall, 1'b1);
            end
        end
        check(is_mem ? "mem_ready_seen" : "if_ready_seen", seen, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          lat;
    logic [31:0] last_load;

    initial begin
        bif.flush = 0; bif.if_req = 0; bif.if_addr = '0;
        bif.mem_req = 0; bif.mem_we = 0; bif.mem_sel = '0; bif.mem_addr = '0; bif.mem_wdata = '0;
        bif.bus_rdata = '0; bif.bus_ack = 0;
        last_load = '0;

        // Reset values
        step(); step();
        check("rst_bus_req",   bif.bus_req,   1'b0);
        check("rst_bus_we",    bif.bus_we,    1'b0);
        check("rst_bus_sel",   bif.bus_sel,   4'h0);
        check("rst_bus_addr",  bif.bus_addr,  32'h0);
        check("rst_bus_wdata", bif.bus_wdata, 32'h0);
        check("rst_if_rdata",  bif.if_rdata,  32'h0);
        check("rst_mem_rdata", bif.mem_rdata, 32'h0);
        check("rst_if_ready",  bif.if_ready,  1'b0);
        check("rst_mem_ready", bif.mem_ready, 1'b0);
        rst = 0;
        step();

        // Fetch with a 2-cycle-late ack
        push_cmd(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h2402_0005, 2);
        if_q.push_back(32'h2402_0005);
        bif.if_req = 1; bif.if_addr = 32'h0000_0100;
        wait_ready(1'b0, 20, lat);
        bif.if_req = 0;
        check("if_latency", lat, 4);
        step();

        // Simultaneous fetch and load: load goes first
        push_cmd(1'b0, 4'hF, 32'h8000_0010, 32'h1111_1111, 32'hCAFE_F00D, 1);
        push_cmd(1'b0, 4'hF, 32'h0000_0200, 32'h0,         32'h0BAD_F00D, 0);
        mem_q.push_back(32'hCAFE_F00D);
        if_q.push_back(32'h0BAD_F00D);
        last_load = 32'hCAFE_F00D;
        bif.mem_req = 1; bif.mem_we = 0; bif.mem_sel = 4'hF;
        bif.mem_addr = 32'h8000_0010; bif.mem_wdata = 32'h1111_1111;
        bif.if_req = 1; bif.if_addr = 32'h0000_0200;
        wait_ready(1'b1, 20, lat);
        bif.mem_req = 0;
        check("mem_latency", lat, 3);
        wait_ready(1'b0, 20, lat);
        bif.if_req = 0;
        step();

        // Store: command held to ack, mem_rdata keeps the last load
        push_cmd(1'b1, 4'b0011, 32'h0000_0040, 32'hDEAD_BEEF, 32'h5555_5555, 2);
        mem_q.push_back(last_load);
        bif.mem_req = 1; bif.mem_we = 1; bif.mem_sel = 4'b0011;
        bif.mem_addr = 32'h0000_0040; bif.mem_wdata = 32'hDEAD_BEEF;
        wait_ready(1'b1, 20, lat);
        bif.mem_req = 0; bif.mem_we = 0;
        step();

        // Flush during a data access does not abort it
        push_cmd(1'b0, 4'hF, 32'h0000_0044, 32'h0, 32'hA5A5_A5A5, 2);
        mem_q.push_back(32'hA5A5_A5A5);
        last_load = 32'hA5A5_A5A5;
        bif.mem_req = 1; bif.mem_sel = 4'hF; bif.mem_addr = 32'h0000_0044; bif.mem_wdata = 32'h0;
        step();
        bif.flush = 1;
        wait_ready(1'b1, 20, lat);
        bif.mem_req = 0; bif.flush = 0;
        step(); step();

        // Flush one cycle into a fetch, ack 3 cycles late: drain, no ready
        push_cmd(1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h7777_7777, 3);
        bif.if_req = 1; bif.if_addr = 32'h0000_0300;
        step();
        bif.flush = 1; bif.if_req = 0;
        step();
        bif.flush = 0;
        for (int i = 0; i < 3; i++) begin
            check("drain_bus_req_held", bif.bus_req, 1'b1);
            check("drain_if_ready", bif.if_ready, 1'b0);
            step();
        end
        check("drain_bus_req_done", bif.bus_req, 1'b0);
        check("drain_if_ready_end", bif.if_ready, 1'b0);
        step();
        check("drain_if_ready_after", bif.if_ready, 1'b0);

        // Flush coinciding with the ack: data discarded
        push_cmd(1'b0, 4'hF, 32'h0000_0308, 32'h0, 32'h9999_9999, 1);
        bif.if_req = 1; bif.if_addr = 32'h0000_0308;
        step(); step();
        bif.flush = 1; bif.if_req = 0;
        step();
        bif.flush = 0;
        check("flushack_bus_req", bif.bus_req, 1'b0);
        check("flushack_if_ready", bif.if_ready, 1'b0);
        check("flushack_if_rdata", bif.if_rdata, 32'h0BAD_F00D);
        step();
        check("flushack_if_ready2", bif.if_ready, 1'b0);

        // Fresh fetch after the flushes
        push_cmd(1'b0, 4'hF, 32'h0000_0304, 32'h0, 32'h1234_5678, 0);
        if_q.push_back(32'h1234_5678);
        bif.if_req = 1; bif.if_addr = 32'h0000_0304;
        wait_ready(1'b0, 20, lat);
        bif.if_req = 0;
        check("if_latency_zero_wait", lat, 2);
        step();

        // Reset during a data access, then a stray ack
        push_cmd(1'b0, 4'hF, 32'h0000_0048, 32'h0, 32'hEEEE_EEEE, 5);
        bif.mem_req = 1; bif.mem_sel = 4'hF; bif.mem_addr = 32'h0000_0048;
        step();
        check("rstmid_bus_req_before", bif.bus_req, 1'b1);
        rst = 1;
        step();
        rst = 0; bif.mem_req = 0;
        check("rstmid_bus_req", bif.bus_req, 1'b0);
        check("rstmid_bus_addr", bif.bus_addr, 32'h0);
        check("rstmid_mem_rdata", bif.mem_rdata, 32'h0);
        last_load = '0;
        stray_cyc = cyc;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stray_mem_ready", bif.mem_ready, 1'b0);
            check("stray_if_ready", bif.if_ready, 1'b0);
            check("stray_bus_req", bif.bus_req, 1'b0);
        end

        // Recovery: zero-wait load
        push_cmd(1'b0, 4'hF, 32'h0000_004C, 32'h0, 32'h0F0F_0F0F, 0);
        mem_q.push_back(32'h0F0F_0F0F);
        bif.mem_req = 1; bif.mem_sel = 4'hF; bif.mem_addr = 32'h0000_004C;
        wait_ready(1'b1, 20, lat);
        bif.mem_req = 0;
        check("mem_latency_zero_wait", lat, 2);
        step(); step(); step();

        check("cmd_q_left", cmd_q.size(), 0);
        check("if_q_left",  if_q.size(),  0);
        check("mem_q_left", mem_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, the width of all address ports.
REQ-002 Parameter DATA_W, default 32, the width of all data ports.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  pipeline flush from the pipeline controller; aborts instruction fetch.
REQ-006 if_req  input  1  instruction-fetch read request, level, held until if_ready.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_rdata  output  DATA_W  fetched word, registered.
REQ-009 if_ready  output  1  one-cycle pulse: if_rdata valid, fetch complete.
REQ-010 mem_req  input  1  data-access request, level, held until mem_ready.
REQ-011 mem_we  input  1  1 = store, 0 = load.
REQ-012 mem_sel  input  4  byte-lane enables.
REQ-013 mem_addr  input  ADDR_W  data address.
REQ-014 mem_wdata  input  DATA_W  store data.
REQ-015 mem_rdata  output  DATA_W  load data, registered.
REQ-016 mem_ready  output  1  one-cycle pulse: data access complete.
REQ-017 bus_req  output  1  shared-bus request, registered.
REQ-018 bus_we, bus_sel[3:0], bus_addr[ADDR_W], bus_wdata[DATA_W]  output  the shared-bus command, registered.
REQ-019 bus_rdata  input  DATA_W  bus read data, valid with bus_ack.
REQ-020 bus_ack  input  1  one-cycle completion pulse from the bus slave.
REQ-021 stallreq_if  output  1  combinational: if_req && !if_ready.
REQ-022 stallreq_mem  output  1  combinational: mem_req && !mem_ready.

Function
REQ-023 States: IDLE, IF_BUSY, MEM_BUSY, IF_DRAIN.
REQ-024 IDLE with mem_req=1 -> MEM_BUSY; bus command is loaded from the mem_* inputs and bus_req=1 from the next cycle.
REQ-025 IDLE with mem_req=0, if_req=1, flush=0 -> IF_BUSY; bus_we=0, bus_sel=4'hF, bus_addr=if_addr.
REQ-026 Priority: data strictly over fetch; simultaneous requests in IDLE -> MEM_BUSY.
REQ-027 IDLE with flush=1 and mem_req=0 -> stays IDLE; if_req is ignored that cycle.
REQ-028 The bus command stays stable while bus_req=1 and changes only on a state transition.
REQ-029 MEM_BUSY with bus_ack=1 -> IDLE; mem_rdata<=bus_rdata (loads; stores leave it unchanged); mem_ready=1 next cycle; bus_req=0 next cycle.
REQ-030 IF_BUSY with bus_ack=1 and flush=0 -> IDLE; if_rdata<=bus_rdata; if_ready=1 next cycle.
REQ-031 IF_BUSY with flush=1 and bus_ack=0 -> IF_DRAIN; bus_req stays 1 until the ack.
REQ-032 IF_BUSY with flush=1 and bus_ack=1 in the same cycle -> IDLE; data discarded; if_ready stays 0.
REQ-033 IF_DRAIN with bus_ack=1 -> IDLE; data discarded; no if_ready.
REQ-034 flush never aborts MEM_BUSY; the access completes and mem_ready pulses.
REQ-035 The arbiter returns to IDLE for at least one cycle between transactions; the minimum transaction is 3 cycles from request to ready with a zero-wait slave.
REQ-036 A bus_ack in IDLE is ignored.
REQ-037 Only one bus transaction is outstanding at any time.

Reset
REQ-038 On rst=1 at a clock edge: state=IDLE; bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0; if_rdata=0, mem_rdata=0, if_ready=0, mem_ready=0.
REQ-039 rst mid-transaction abandons the transaction; a late bus_ack after reset is ignored per REQ-036.

Verification
REQ-040 if_req=1, if_addr=0x00000100; slave acks 2 cycles after bus_req with rdata=0x24020005 -> if_rdata=0x24020005, if_ready one pulse; stallreq_if high until then.
REQ-041 if_req and mem_req (load, addr 0x80000010) asserted in the same IDLE cycle -> bus_addr=0x80000010 first; after mem_ready the fetch is issued.
REQ-042 Store: mem_we=1, sel=4'b0011, wdata=0xDEADBEEF -> bus_we=1, bus_sel=4'b0011, bus_wdata=0xDEADBEEF held to ack; mem_rdata unchanged.
REQ-043 flush pulses one cycle into IF_BUSY with a 3-cycle-late ack -> bus_req held until ack; no if_ready; the next if_req starts a fresh fetch.
REQ-044 rst asserted while in MEM_BUSY -> next cycle bus_req=0, state IDLE; a subsequent stray bus_ack produces no ready pulse.
REQ-045 flush asserted during MEM_BUSY -> the access completes; mem_ready pulses once.
